// File: rtl/hls_dataflow_perf_monitor.sv
// hls_dataflow_perf_monitor
// Per-channel statistics for HLS ap_ctrl_hs blocks: transaction count, latency
// (last/min/max), busy occupancy, loop iterations and stalls, with sticky
// saturation flags. All counters saturate. Stats are read through a registered
// channel/select port.
module hls_dataflow_perf_monitor #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32,
  parameter int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic              clock,
  input  logic              reset,
  input  logic [NUM_CH-1:0] ap_start,
  input  logic [NUM_CH-1:0] ap_done,
  input  logic [NUM_CH-1:0] ap_continue,
  input  logic [NUM_CH-1:0] iter_end,
  input  logic [NUM_CH-1:0] stall,
  input  logic              freeze,
  input  logic              clear,
  input  logic [CH_W-1:0]   rd_ch,
  input  logic [2:0]        rd_sel,
  output logic [CNT_W-1:0]  rd_data,
  output logic [NUM_CH-1:0] busy
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_RUN = 2'd1, S_HOLD = 2'd2} state_t;

  localparam logic [CNT_W-1:0] MAX = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == MAX) ? v : v + ONE;
  endfunction

  state_t            state_q [NUM_CH];
  state_t            state_d [NUM_CH];
  logic [CNT_W-1:0]  lat_q   [NUM_CH];
  logic [CNT_W-1:0]  lat_d   [NUM_CH];
  logic [CNT_W-1:0]  rec_lat [NUM_CH];
  logic [CNT_W-1:0]  txn_q   [NUM_CH];
  logic [CNT_W-1:0]  last_q  [NUM_CH];
  logic [CNT_W-1:0]  min_q   [NUM_CH];
  logic [CNT_W-1:0]  max_q   [NUM_CH];
  logic [CNT_W-1:0]  busyc_q [NUM_CH];
  logic [CNT_W-1:0]  iter_q  [NUM_CH];
  logic [CNT_W-1:0]  stallc_q[NUM_CH];
  logic [5:0]        sat_q   [NUM_CH];
  logic [NUM_CH-1:0] txn_ev, rec_ev, busy_ev;
  logic [NUM_CH-1:0] busy_q;
  logic [CNT_W-1:0]  rd_data_q, rd_data_d;

  // Handshake decode: next state, running latency and per-cycle statistic events.
  // The start-sample cycle counts as busy so busy_cycles equals the latency
  // of a transaction that completes without backpressure.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      state_d[c] = state_q[c];
      lat_d[c]   = lat_q[c];
      rec_lat[c] = ONE;
      txn_ev[c]  = 1'b0;
      rec_ev[c]  = 1'b0;
      busy_ev[c] = 1'b0;
      case (state_q[c])
        S_IDLE: begin
          if (ap_start[c]) begin
            busy_ev[c] = 1'b1;
            if (ap_done[c]) begin
              rec_ev[c] = 1'b1;
              if (ap_continue[c]) txn_ev[c] = 1'b1;
              else                state_d[c] = S_HOLD;
            end else begin
              state_d[c] = S_RUN;
              lat_d[c]   = ONE;
            end
          end
        end
        S_RUN: begin
          busy_ev[c] = 1'b1;
          lat_d[c]   = sat_inc(lat_q[c]);
          rec_lat[c] = sat_inc(lat_q[c]);
          if (ap_done[c]) begin
            rec_ev[c] = 1'b1;
            if (ap_continue[c]) begin
              txn_ev[c]  = 1'b1;
              state_d[c] = S_IDLE;
            end else begin
              state_d[c] = S_HOLD;
            end
          end
        end
        S_HOLD: begin
          busy_ev[c] = 1'b1;
          if (ap_done[c] && ap_continue[c]) begin
            txn_ev[c]  = 1'b1;
            state_d[c] = S_IDLE;
          end
        end
        default: state_d[c] = S_IDLE;
      endcase
    end
  end

  // Channel FSMs, running latency and registered busy decode; untouched by clear/freeze.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= S_IDLE;
        lat_q[c]   <= '0;
      end
      busy_q <= '0;
    end else begin
      for (int c = 0; c < NUM_CH; c++) begin
        state_q[c] <= state_d[c];
        lat_q[c]   <= lat_d[c];
        busy_q[c]  <= (state_d[c] != S_IDLE);
      end
    end
  end

  // Statistic counters: clear wins over everything, freeze blocks all updates.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int c = 0; c < NUM_CH; c++) begin
        txn_q[c] <= '0; last_q[c] <= '0; min_q[c] <= MAX; max_q[c] <= '0;
        busyc_q[c] <= '0; iter_q[c] <= '0; stallc_q[c] <= '0; sat_q[c] <= '0;
      end
    end else if (clear) begin
      for (int c = 0; c < NUM_CH; c++) begin
        txn_q[c] <= '0; last_q[c] <= '0; min_q[c] <= MAX; max_q[c] <= '0;
        busyc_q[c] <= '0; iter_q[c] <= '0; stallc_q[c] <= '0; sat_q[c] <= '0;
      end
    end else if (!freeze) begin
      for (int c = 0; c < NUM_CH; c++) begin
        if (txn_ev[c]) begin
          txn_q[c] <= sat_inc(txn_q[c]);
          if (sat_inc(txn_q[c]) == MAX) sat_q[c][0] <= 1'b1;
        end
        if (rec_ev[c]) begin
          last_q[c] <= rec_lat[c];
          if (rec_lat[c] < min_q[c]) min_q[c] <= rec_lat[c];
          if (rec_lat[c] > max_q[c]) max_q[c] <= rec_lat[c];
          if (rec_lat[c] == MAX) sat_q[c][1] <= 1'b1;
        end
        if (busy_ev[c]) begin
          busyc_q[c] <= sat_inc(busyc_q[c]);
          if (sat_inc(busyc_q[c]) == MAX) sat_q[c][2] <= 1'b1;
        end
        if (iter_end[c]) begin
          iter_q[c] <= sat_inc(iter_q[c]);
          if (sat_inc(iter_q[c]) == MAX) sat_q[c][3] <= 1'b1;
        end
        if (stall[c] && state_q[c] == S_RUN) begin
          stallc_q[c] <= sat_inc(stallc_q[c]);
          if (sat_inc(stallc_q[c]) == MAX) sat_q[c][4] <= 1'b1;
        end
        if (state_q[c] == S_RUN && lat_d[c] == MAX) sat_q[c][5] <= 1'b1;
      end
    end
  end

  // Read-port select; out-of-range channels read as zero.
  always_comb begin
    rd_data_d = '0;
    if (int'(rd_ch) < NUM_CH) begin
      case (rd_sel)
        3'd0: rd_data_d = txn_q[rd_ch];
        3'd1: rd_data_d = last_q[rd_ch];
        3'd2: rd_data_d = min_q[rd_ch];
        3'd3: rd_data_d = max_q[rd_ch];
        3'd4: rd_data_d = busyc_q[rd_ch];
        3'd5: rd_data_d = iter_q[rd_ch];
        3'd6: rd_data_d = stallc_q[rd_ch];
        3'd7: rd_data_d[7:0] = {sat_q[rd_ch], state_q[rd_ch]};
      endcase
    end
  end

  // Registered read data.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) rd_data_q <= '0;
    else        rd_data_q <= rd_data_d;
  end

  assign rd_data = rd_data_q;
  assign busy    = busy_q;

endmodule

// File: tb/tb_hls_dataflow_perf_monitor.sv
// Testbench for hls_dataflow_perf_monitor: directed scenarios plus random
// traffic against a transaction-level reference model, with a queue-based
// scoreboard checked by an independent monitor process.
`timescale 1ns/1ps
module tb_hls_dataflow_perf_monitor;
  localparam int NCH  = 5;
  localparam int CW   = 8;
  localparam int CHW  = 3;
  localparam int MAXV = 255;

  logic           clock = 1'b0;
  logic           reset = 1'b1;
  logic [NCH-1:0] ap_start = '0, ap_done = '0, ap_continue = '1, iter_end = '0, stall = '0;
  logic           freeze = 1'b0, clear = 1'b0;
  logic [CHW-1:0] rd_ch = '0;
  logic [2:0]     rd_sel = '0;
  logic [CW-1:0]  rd_data;
  logic [NCH-1:0] busy;

  always #5 clock = ~clock;

  hls_dataflow_perf_monitor #(.NUM_CH(NCH), .CNT_W(CW), .CH_W(CHW)) dut (
    .clock(clock), .reset(reset), .ap_start(ap_start), .ap_done(ap_done),
    .ap_continue(ap_continue), .iter_end(iter_end), .stall(stall),
    .freeze(freeze), .clear(clear), .rd_ch(rd_ch), .rd_sel(rd_sel),
    .rd_data(rd_data), .busy(busy)
  );

  typedef struct { int ch; int sel; int val; } rd_exp_t;
  rd_exp_t rd_q[$];
  int      bq[$];
  logic    rd_req = 1'b0, cyc_act = 1'b0, rd_pend = 1'b0, cy_pend = 1'b0;
  int      checks = 0, failures = 0;

  always @(posedge clock) begin
    rd_pend <= rd_req;
    cy_pend <= cyc_act;
  end

  // Reference model: per channel phase (0 idle, 1 running, 2 awaiting continue)
  // and the cycle the transaction started; latency is elapsed cycles.
  int ph[NCH], t0[NCH];
  int m_txn[NCH], m_last[NCH], m_min[NCH], m_max[NCH];
  int m_busy[NCH], m_iter[NCH], m_stall[NCH];
  logic [5:0] m_sat[NCH];
  int cyc = 0;

  function automatic int sinc(int v);
    return (v < MAXV) ? v + 1 : MAXV;
  endfunction

  task automatic model_clear();
    for (int c = 0; c < NCH; c++) begin
      m_txn[c] = 0; m_last[c] = 0; m_min[c] = MAXV; m_max[c] = 0;
      m_busy[c] = 0; m_iter[c] = 0; m_stall[c] = 0; m_sat[c] = '0;
    end
  endtask

  task automatic model_reset();
    model_clear();
    for (int c = 0; c < NCH; c++) begin ph[c] = 0; t0[c] = 0; end
  endtask

  task automatic model_step();
    for (int c = 0; c < NCH; c++) begin
      int nph, rlat;
      bit e_txn, e_rec, e_busy, e_stall, e_lsat;
      nph = ph[c]; rlat = 1;
      e_txn = 0; e_rec = 0; e_busy = 0; e_stall = 0; e_lsat = 0;
      if (ph[c] == 0) begin
        if (ap_start[c]) begin
          e_busy = 1; t0[c] = cyc;
          if (ap_done[c]) begin
            e_rec = 1; rlat = 1;
            if (ap_continue[c]) e_txn = 1; else nph = 2;
          end else nph = 1;
        end
      end else if (ph[c] == 1) begin
        e_busy = 1; e_stall = stall[c];
        rlat = (cyc - t0[c] + 1 < MAXV) ? cyc - t0[c] + 1 : MAXV;
        e_lsat = (rlat == MAXV);
        if (ap_done[c]) begin
          e_rec = 1;
          if (ap_continue[c]) begin e_txn = 1; nph = 0; end else nph = 2;
        end
      end else begin
        e_busy = 1;
        if (ap_done[c] && ap_continue[c]) begin e_txn = 1; nph = 0; end
      end
      if (clear) begin
        m_txn[c] = 0; m_last[c] = 0; m_min[c] = MAXV; m_max[c] = 0;
        m_busy[c] = 0; m_iter[c] = 0; m_stall[c] = 0; m_sat[c] = '0;
      end else if (!freeze) begin
        if (e_txn) begin m_txn[c] = sinc(m_txn[c]); if (m_txn[c] == MAXV) m_sat[c][0] = 1'b1; end
        if (e_rec) begin
          m_last[c] = rlat;
          if (rlat < m_min[c]) m_min[c] = rlat;
          if (rlat > m_max[c]) m_max[c] = rlat;
          if (rlat == MAXV) m_sat[c][1] = 1'b1;
        end
        if (e_busy) begin m_busy[c] = sinc(m_busy[c]); if (m_busy[c] == MAXV) m_sat[c][2] = 1'b1; end
        if (iter_end[c]) begin m_iter[c] = sinc(m_iter[c]); if (m_iter[c] == MAXV) m_sat[c][3] = 1'b1; end
        if (e_stall) begin m_stall[c] = sinc(m_stall[c]); if (m_stall[c] == MAXV) m_sat[c][4] = 1'b1; end
        if (e_lsat) m_sat[c][5] = 1'b1;
      end
      ph[c] = nph;
    end
    cyc++;
  endtask

  function automatic int exp_rd(int ch, int sel);
    if (ch >= NCH) return 0;
    case (sel)
      0: return m_txn[ch];
      1: return m_last[ch];
      2: return m_min[ch];
      3: return m_max[ch];
      4: return m_busy[ch];
      5: return m_iter[ch];
      6: return m_stall[ch];
      default: return (int'(m_sat[ch]) << 2) | ph[ch];
    endcase
  endfunction

  // One clock of stimulus: queue expectations, advance model, clock the DUT.
  task automatic cycle();
    rd_exp_t e;
    int b;
    if (rd_req) begin
      e.ch = int'(rd_ch); e.sel = int'(rd_sel); e.val = exp_rd(e.ch, e.sel);
      rd_q.push_back(e);
    end
    model_step();
    b = 0;
    for (int c = 0; c < NCH; c++) if (ph[c] != 0) b |= (1 << c);
    bq.push_back(b);
    cyc_act = 1'b1;
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic ev_idle();
    ap_start = '0; ap_done = '0; ap_continue = '1; iter_end = '0; stall = '0;
    clear = 1'b0; rd_req = 1'b0;
  endtask

  task automatic idle(int n);
    ev_idle();
    repeat (n) cycle();
  endtask

  task automatic rd(int ch, int sel);
    rd_ch = CHW'(ch); rd_sel = 3'(sel); rd_req = 1'b1;
    cycle();
    rd_req = 1'b0;
  endtask

  task automatic read_all(int ch);
    for (int s = 0; s < 8; s++) rd(ch, s);
  endtask

  // Transaction of latency L, then H cycles waiting for continue.
  task automatic txn(int c, int L, int H);
    ap_start[c] = 1'b1;
    if (L == 1) begin ap_done[c] = 1'b1; ap_continue[c] = (H == 0); end
    cycle();
    ap_start[c] = 1'b0; ap_done[c] = 1'b0; ap_continue[c] = 1'b1;
    if (L > 1) begin
      repeat (L - 2) cycle();
      ap_done[c] = 1'b1; ap_continue[c] = (H == 0);
      cycle();
    end
    if (H > 0) begin
      repeat (H - 1) begin ap_done[c] = 1'b1; ap_continue[c] = 1'b0; cycle(); end
      ap_done[c] = 1'b1; ap_continue[c] = 1'b1;
      cycle();
    end
    ap_done[c] = 1'b0; ap_continue[c] = 1'b1;
  endtask

  // Monitor: compares DUT outputs against queued expectations.
  initial begin : monitor
    rd_exp_t e;
    logic [CW-1:0] ev;
    logic [NCH-1:0] eb;
    bit in_rst;
    in_rst = 0;
    forever begin
      @(negedge clock or negedge reset);
      if (!reset) begin
        if (!in_rst) begin
          in_rst = 1;
          #1;
          checks++;
          if (rd_data !== '0) begin
            failures++;
            $display("FAIL async_reset_rd_data: got %0h expected 0", rd_data);
          end
          checks++;
          if (busy !== '0) begin
            failures++;
            $display("FAIL async_reset_busy: got %b expected 0", busy);
          end
        end
      end else begin
        in_rst = 0;
        if (rd_pend) begin
          checks++;
          if (rd_q.size() == 0) begin
            failures++;
            $display("FAIL rd_queue_empty: got %0h with no expectation", rd_data);
          end else begin
            e = rd_q.pop_front();
            ev = e.val[CW-1:0];
            if (rd_data !== ev) begin
              failures++;
              $display("FAIL rd ch%0d sel%0d: got %0h expected %0h", e.ch, e.sel, rd_data, ev);
            end
          end
        end
        if (cy_pend && bq.size() != 0) begin
          eb = bq[0][NCH-1:0];
          void'(bq.pop_front());
          checks++;
          if (busy !== eb) begin
            failures++;
            $display("FAIL busy: got %b expected %b", busy, eb);
          end
        end
      end
    end
  end

  initial begin : watchdog
    #300000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1, "timeout");
  end

  initial begin : driver
    #1 reset = 1'b0;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    read_all(0);
    read_all(4);
    rd(5, 7);
    rd(7, 0);

    // Basic transaction of latency 8 on ch0.
    idle(10);
    txn(0, 8, 0);
    idle(1);
    read_all(0);

    // ch1: done with continue low, four cycles in HOLD.
    ev_idle();
    ap_start[1] = 1'b1; cycle(); ap_start[1] = 1'b0;
    repeat (4) cycle();
    ap_done[1] = 1'b1; ap_continue[1] = 1'b0; cycle();
    repeat (2) cycle();
    rd(1, 0);
    ap_continue[1] = 1'b1;
    rd(1, 7);
    idle(1);
    read_all(1);

    // ch2: latencies 5, 3, 9, then single-cycle, then single-cycle into HOLD.
    txn(2, 5, 0); idle(2);
    txn(2, 3, 0); idle(1);
    txn(2, 9, 0); idle(1);
    read_all(2);
    txn(2, 1, 0); idle(1);
    rd(2, 2); rd(2, 0);
    txn(2, 1, 2); idle(1);
    read_all(2);

    // ch3: stalls in IDLE ignored, iterations and stalls in RUN counted.
    ev_idle();
    stall[3] = 1'b1; cycle(); cycle(); stall[3] = 1'b0;
    ap_start[3] = 1'b1; cycle(); ap_start[3] = 1'b0;
    for (int i = 0; i < 20; i++) begin
      iter_end[3] = (i < 16);
      stall[3]    = (i >= 3 && i < 9);
      cycle();
    end
    iter_end[3] = 1'b0; stall[3] = 1'b0;
    ap_done[3] = 1'b1; cycle(); ap_done[3] = 1'b0;
    idle(1);
    read_all(3);

    // ch4: counter saturation, clear, latency saturation.
    ev_idle();
    for (int i = 0; i < 300; i++) begin iter_end[4] = 1'b1; cycle(); end
    idle(1);
    rd(4, 5); rd(4, 7);
    clear = 1'b1; cycle(); clear = 1'b0;
    idle(1);
    rd(4, 5); rd(4, 7);
    txn(4, 260, 0);
    idle(1);
    read_all(4);

    // Freeze holds statistics while the FSM keeps tracking; clear acts under freeze.
    ev_idle();
    freeze = 1'b1;
    iter_end[0] = 1'b1; cycle(); iter_end[0] = 1'b0;
    txn(0, 6, 0);
    freeze = 1'b0;
    idle(1);
    read_all(0);
    freeze = 1'b1; clear = 1'b1; cycle(); clear = 1'b0; freeze = 1'b0;
    idle(1);
    rd(0, 0); rd(0, 2); rd(3, 5);

    // Clear mid-transaction: start, clear 4 cycles later, done 3 cycles after that.
    ev_idle();
    ap_start[1] = 1'b1; cycle(); ap_start[1] = 1'b0;
    repeat (3) cycle();
    clear = 1'b1; cycle(); clear = 1'b0;
    repeat (2) cycle();
    ap_done[1] = 1'b1; cycle(); ap_done[1] = 1'b0;
    idle(1);
    read_all(1);

    // Random traffic on all channels.
    for (int i = 0; i < 400; i++) begin
      for (int c = 0; c < NCH; c++) begin
        ap_start[c]    = ($urandom_range(0, 3) == 0);
        ap_done[c]     = ($urandom_range(0, 2) == 0);
        ap_continue[c] = ($urandom_range(0, 3) != 0);
        iter_end[c]    = ($urandom_range(0, 1) == 0);
        stall[c]       = ($urandom_range(0, 2) == 0);
      end
      freeze = ($urandom_range(0, 19) == 0);
      clear  = ($urandom_range(0, 49) == 0);
      rd_ch  = CHW'($urandom_range(0, 7));
      rd_sel = 3'($urandom_range(0, 7));
      rd_req = 1'b1;
      cycle();
    end
    freeze = 1'b0;
    idle(2);

    // Async reset while ch0 is running aborts the transaction.
    ap_start[0] = 1'b1; cycle(); ap_start[0] = 1'b0;
    repeat (2) cycle();
    rd(0, 7);
    idle(2);
    cyc_act = 1'b0;
    #2 reset = 1'b0;
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
    model_reset();
    read_all(0);
    idle(2);
    cyc_act = 1'b0;
    @(negedge clock);
    @(negedge clock);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
